ccu_cd_router: RTL and testbench
================================

Name: ccu_cd_router

Overview:
- Parametrised router for snoop CD (cache data) beats returned on read-snoop hits in the CCU.
- Each beat is steered to the initiator's R channel, to a memory write-back W channel, or to both.
- Per-transaction control comes from a queue of descriptors, one per outstanding line.
- Compared with the previous single-mode router, it adds:
  - a configurable descriptor queue depth;
  - a per-transaction wrap mode: beats before the critical beat are buffered and replayed after the line tail, so WRAP bursts return in critical-word-first order;
  - CD framing-error detection.

Parameters:
- DATA_WIDTH, 64, CD/R/W data width in bits.
- ID_WIDTH, 4, AXI ID width.
- USER_WIDTH, 1, AXI user width.
- LEN_WIDTH, 8, AR len width.
- LINE_BEATS, 4, CD beats per cacheline; power of two, >=2.
- DESC_DEPTH, 4, descriptor FIFO depth, >=1.
- OFF_W, $clog2(LINE_BEATS), beat-offset width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- desc_valid_i  in  1  descriptor valid
- desc_ready_o  out  1  descriptor FIFO not full
- desc_id_i  in  ID_WIDTH  R id
- desc_len_i  in  LEN_WIDTH  AR len (beats-1)
- desc_offset_i  in  OFF_W  index of first requested beat within the line
- desc_resp_i  in  2  {IsShared, PassDirty} for R resp[3:2]
- desc_user_i  in  USER_WIDTH  W user
- desc_fwd_i  in  1  forward to R
- desc_wb_i  in  1  write back to W
- desc_wrap_i  in  1  1: buffer and replay beats before the offset; 0: drop them
- cd_valid_i  in  1  CD beat valid
- cd_ready_o  out  1  CD beat accepted
- cd_data_i  in  DATA_WIDTH  CD data
- cd_last_i  in  1  CD last
- r_valid_o / r_ready_i  out/in  1  R handshake
- r_id_o  out  ID_WIDTH  R id
- r_data_o  out  DATA_WIDTH  R data
- r_resp_o  out  4  {desc_resp, 2'b00}
- r_last_o  out  1  R last
- w_valid_o / w_ready_i  out/in  1  W handshake
- w_data_o  out  DATA_WIDTH  W data
- w_strb_o  out  DATA_WIDTH/8  W strobe, all ones
- w_last_o  out  1  equals cd_last_i
- w_user_o  out  USER_WIDTH  W user
- err_o  out  1  one-cycle framing-error pulse
- busy_o  out  1  descriptor FIFO non-empty or state != IDLE

Behaviour:

Reset:
- rst_i high at a clock edge: FIFO empty, state IDLE, beat counter b=0, R counter rc=0, sent flags cleared.
- Next cycle: all valids 0, cd_ready_o=0, err_o=0, desc_ready_o=1, busy_o=0.
- A reset mid-line abandons the line; its remaining CD beats are not consumed.

Descriptor FIFO:
- Push on desc_valid_i && desc_ready_o.
- Head is popped in the cycle its line completes.
- Push and pop in the same cycle on a full FIFO is allowed; the FIFO stays full.

State machine (IDLE, STREAM, REPLAY):
- IDLE -> STREAM when the FIFO is non-empty; b and rc clear.
- In STREAM, each CD beat at index b selects its sinks:
  - W selected iff wb.
  - R selected iff fwd && b>=offset && rc<=len.
  - If wrap && b<offset, the beat is written into the replay buffer (LINE_BEATS-1 entries, index b). The buffer is always writable.
- Handshake uses fork semantics:
  - Each selected output holds valid with stable data until its own handshake.
  - A per-output sent flag records completion.
  - cd_ready_o=1 in the cycle the last outstanding selected output handshakes, or immediately if no output is selected.
  - No valid depends on its own ready.
- On CD accept: b++. R handshake: rc++.
- r_last_o=1 when rc==len or the beat is the last R-eligible beat of the line.
- On accepting a beat with cd_last_i:
  - wrap && fwd && offset>0 && rc<=len -> REPLAY.
  - Otherwise pop the head and go to STREAM if the FIFO still holds a descriptor after the pop, else IDLE.
- REPLAY:
  - Emit buffer[0..offset-1] on R while rc<=len; cd_ready_o=0.
  - After the beat carrying r_last, pop and go to STREAM/IDLE as above.

Framing check:
- err_o pulses for one cycle if cd_last_i is accepted with b!=LINE_BEATS-1, or is absent at b==LINE_BEATS-1.
- cd_last_i is authoritative for line end. Beats with b>=LINE_BEATS go to W only.

Width rules:
- b counter is OFF_W+1 bits; rc is LEN_WIDTH+1 bits, so neither wraps.

Latency:
- Combinational CD->R/W pass-through.
- Zero bubble between back-to-back lines.
- One cycle IDLE->STREAM.

Test Plan:
1. Drop mode: LINE_BEATS=4, desc{fwd=1, wb=0, offset=2, len=1, wrap=0}; CD D0..D3 -> R D2, D3 with r_last on D3; D0, D1 consumed with no output; err_o=0; busy_o=0 afterwards.
2. Wrap mode: desc{fwd=1, offset=1, len=3, wrap=1}; CD D0..D3 -> R order D1, D2, D3, D0; r_last only on D0; cd_ready_o=0 during the D0 replay.
3. Dual route: desc{fwd=1, wb=1, offset=0, len=3, resp=2'b10}; w_ready_i low for 3 cycles at beat 1 -> R D1 issued once and not repeated; W D0..D3 with strb all ones and w_last on D3; r_resp_o=4'b1000.
4. Queue full: push 5 descriptors with ids 1..5 while cd_valid_i=0 -> desc_ready_o=0 after the 4th; lines drain in order; R ids 1..4 then 5.
5. Framing error: cd_last_i on beat 2 -> err_o=1 for exactly one cycle; head popped; next line starts at b=0.
6. Reset during REPLAY -> next cycle r_valid_o=0, w_valid_o=0, err_o=0, desc_ready_o=1, busy_o=0.

Source files
------------

// File: rtl/ccu_cd_router.sv
// ccu_cd_router: steers snoop CD beats to R, W or both under per-line descriptors, with critical-word-first replay
module ccu_cd_router #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 8,
    parameter int LINE_BEATS = 4,
    parameter int DESC_DEPTH = 4,
    parameter int OFF_W      = $clog2(LINE_BEATS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [ID_WIDTH-1:0]     desc_id_i,
    input  logic [LEN_WIDTH-1:0]    desc_len_i,
    input  logic [OFF_W-1:0]        desc_offset_i,
    input  logic [1:0]              desc_resp_i,
    input  logic [USER_WIDTH-1:0]   desc_user_i,
    input  logic                    desc_fwd_i,
    input  logic                    desc_wb_i,
    input  logic                    desc_wrap_i,
    input  logic                    cd_valid_i,
    output logic                    cd_ready_o,
    input  logic [DATA_WIDTH-1:0]   cd_data_i,
    input  logic                    cd_last_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [3:0]              r_resp_o,
    output logic                    r_last_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    output logic [USER_WIDTH-1:0]   w_user_o,
    output logic                    err_o,
    output logic                    busy_o
);
    localparam int PW = DESC_DEPTH > 1 ? $clog2(DESC_DEPTH) : 1;
    localparam int CW = $clog2(DESC_DEPTH + 1);
    localparam logic [OFF_W:0] LB  = (OFF_W + 1)'(LINE_BEATS);
    localparam logic [OFF_W:0] LB1 = (OFF_W + 1)'(LINE_BEATS - 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [LEN_WIDTH-1:0]  len;
        logic [OFF_W-1:0]      off;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
        logic                  fwd;
        logic                  wb;
        logic                  wrap;
    } desc_t;

    typedef enum logic [1:0] {IDLE, STREAM, REPLAY} state_t;

    desc_t                 mem [DESC_DEPTH];
    desc_t                 h;
    desc_t                 d_in;
    logic [PW-1:0]         wp, rp;
    logic [CW-1:0]         cnt, cnt_nx;
    state_t                state;
    logic [OFF_W:0]        b, off_x;
    logic [LEN_WIDTH:0]    rc, rc_nx, len_x;
    logic                  r_sent, w_sent;
    logic [DATA_WIDTH-1:0] rbuf [LINE_BEATS-1];
    logic                  stream, replay, push, pop, full, sel_r, sel_w;
    logic                  cd_acc, r_hs, w_hs, tail_wrap, go_replay, line_end, more;

    assign d_in      = {desc_id_i, desc_len_i, desc_offset_i, desc_resp_i, desc_user_i,
                        desc_fwd_i, desc_wb_i, desc_wrap_i};
    assign h         = mem[rp];
    assign len_x     = {1'b0, h.len};
    assign off_x     = {1'b0, h.off};
    assign stream    = state == STREAM;
    assign replay    = state == REPLAY;
    assign full      = cnt == CW'(DESC_DEPTH);
    assign push      = desc_valid_i && desc_ready_o;
    assign desc_ready_o = !full || pop;
    assign sel_w     = h.wb;
    assign sel_r     = h.fwd && b < LB && b >= off_x && rc <= len_x;
    assign r_valid_o = replay || (stream && cd_valid_i && sel_r && !r_sent);
    assign w_valid_o = stream && cd_valid_i && sel_w && !w_sent;
    assign cd_ready_o = stream && (!sel_r || r_sent || r_ready_i) && (!sel_w || w_sent || w_ready_i);
    assign cd_acc    = cd_valid_i && cd_ready_o;
    assign r_hs      = r_valid_o && r_ready_i;
    assign w_hs      = w_valid_o && w_ready_i;
    assign tail_wrap = h.wrap && h.off != '0;
    assign r_last_o  = rc == len_x || (replay ? b == off_x - 1'b1 : (b == LB1 || cd_last_i) && !tail_wrap);
    assign rc_nx     = rc + {{LEN_WIDTH{1'b0}}, r_hs};
    assign go_replay = tail_wrap && h.fwd && rc_nx <= len_x;
    assign line_end  = stream && cd_acc && cd_last_i;
    assign pop       = (line_end && !go_replay) || (replay && r_hs && r_last_o);
    assign cnt_nx    = cnt + CW'(push) - CW'(pop);
    assign more      = cnt_nx != '0;
    assign r_id_o    = h.id;
    assign r_data_o  = replay ? rbuf[b[OFF_W-1:0]] : cd_data_i;
    assign r_resp_o  = {h.resp, 2'b00};
    assign w_data_o  = cd_data_i;
    assign w_strb_o  = '1;
    assign w_last_o  = cd_last_i;
    assign w_user_o  = h.user;
    assign busy_o    = cnt != '0 || state != IDLE;

    // Descriptor storage and the pre-offset beats held for replay
    always_ff @(posedge clk_i) begin
        if (push) mem[wp] <= d_in;
        if (stream && cd_acc && h.wrap && b < off_x) rbuf[b[OFF_W-1:0]] <= cd_data_i;
    end

    // Descriptor FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp == PW'(DESC_DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(DESC_DEPTH - 1) ? '0 : rp + 1'b1;
            cnt <= cnt_nx;
        end
    end

    // Line sequencing: streaming with fork handshakes, tail replay and framing check
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            b      <= '0;
            rc     <= '0;
            r_sent <= 1'b0;
            w_sent <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            err_o <= stream && cd_acc && (cd_last_i != (b == LB1));
            case (state)
                IDLE: begin
                    b  <= '0;
                    rc <= '0;
                    if (cnt != '0) state <= STREAM;
                end
                STREAM: begin
                    rc <= rc_nx;
                    if (cd_acc) begin
                        r_sent <= 1'b0;
                        w_sent <= 1'b0;
                        b      <= b == '1 ? b : b + 1'b1;
                        if (cd_last_i) begin
                            b <= '0;
                            if (go_replay) begin
                                state <= REPLAY;
                            end else begin
                                state <= more ? STREAM : IDLE;
                                rc    <= '0;
                            end
                        end
                    end else begin
                        if (r_hs) r_sent <= 1'b1;
                        if (w_hs) w_sent <= 1'b1;
                    end
                end
                REPLAY: begin
                    if (r_hs) begin
                        b  <= b + 1'b1;
                        rc <= rc_nx;
                        if (r_last_o) begin
                            state <= more ? STREAM : IDLE;
                            b     <= '0;
                            rc    <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccu_cd_router.sv
// tb_ccu_cd_router: directed and randomized checks of CD routing against a line-level reference model
module tb_ccu_cd_router;
    localparam int DW = 64, IW = 4, UW = 1, LW = 8, L = 4, DD = 4, OW = 2;
    localparam int RWID = IW + 4 + 1 + DW;
    localparam int WWID = UW + DW / 8 + 1 + DW;

    logic          clk_i = 0, rst_i = 0;
    logic          desc_valid_i = 0, desc_ready_o;
    logic [IW-1:0] desc_id_i = 0;
    logic [LW-1:0] desc_len_i = 0;
    logic [OW-1:0] desc_offset_i = 0;
    logic [1:0]    desc_resp_i = 0;
    logic [UW-1:0] desc_user_i = 0;
    logic          desc_fwd_i = 0, desc_wb_i = 0, desc_wrap_i = 0;
    logic          cd_valid_i = 0, cd_ready_o, cd_last_i = 0;
    logic [DW-1:0] cd_data_i = 0;
    logic          r_valid_o, r_ready_i = 0, r_last_o;
    logic [IW-1:0] r_id_o;
    logic [DW-1:0] r_data_o, w_data_o;
    logic [3:0]    r_resp_o;
    logic          w_valid_o, w_ready_i = 0, w_last_o;
    logic [DW/8-1:0] w_strb_o;
    logic [UW-1:0] w_user_o;
    logic          err_o, busy_o;

    ccu_cd_router #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .LEN_WIDTH(LW),
                    .LINE_BEATS(L), .DESC_DEPTH(DD)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_id_i(desc_id_i),
        .desc_len_i(desc_len_i), .desc_offset_i(desc_offset_i), .desc_resp_i(desc_resp_i),
        .desc_user_i(desc_user_i), .desc_fwd_i(desc_fwd_i), .desc_wb_i(desc_wb_i),
        .desc_wrap_i(desc_wrap_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_last_o(w_last_o), .w_user_o(w_user_o),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IW-1:0] id;
        int            len;
        int            off;
        logic [1:0]    resp;
        logic [UW-1:0] user;
        bit            fwd, wb, wrap;
    } dsc_t;

    // Monitor: log every R/W handshake and count err_o cycles
    logic [RWID-1:0] r_log [4096];
    logic            r_crdy [4096];
    logic [WWID-1:0] w_log [4096];
    int r_n = 0, w_n = 0, err_n = 0;
    always @(negedge clk_i) begin
        if (r_valid_o && r_ready_i) begin
            r_log[r_n]  <= {r_id_o, r_resp_o, r_last_o, r_data_o};
            r_crdy[r_n] <= cd_ready_o;
            r_n         <= r_n + 1;
        end
        if (w_valid_o && w_ready_i) begin
            w_log[w_n] <= {w_user_o, w_strb_o, w_last_o, w_data_o};
            w_n        <= w_n + 1;
        end
        if (err_o) err_n <= err_n + 1;
    end

    int checks = 0, errors = 0;
    int r_pct = 100, w_pct = 100, w_hold = 0;
    int r_rd = 0, w_rd = 0, err_rd = 0, exp_err = 0;
    logic [RWID-1:0] exp_r[$];
    logic [WWID-1:0] exp_w[$];
    dsc_t dq[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(output bit acc);
        logic dr;
        r_ready_i = int'($urandom_range(99)) < r_pct;
        w_ready_i = w_hold > 0 ? 1'b0 : int'($urandom_range(99)) < w_pct;
        if (w_hold > 0) w_hold--;
        #3;
        dr  = desc_ready_o;
        acc = cd_valid_i && cd_ready_o;
        @(posedge clk_i);
        #1;
        if (desc_valid_i && dr) desc_valid_i = 0;
    endtask

    task automatic put(input dsc_t d);
        desc_id_i     = d.id;
        desc_len_i    = LW'(d.len);
        desc_offset_i = OW'(d.off);
        desc_resp_i   = d.resp;
        desc_user_i   = d.user;
        desc_fwd_i    = d.fwd;
        desc_wb_i     = d.wb;
        desc_wrap_i   = d.wrap;
        desc_valid_i  = 1;
        dq.push_back(d);
    endtask

    task automatic push(input dsc_t d);
        bit a;
        put(d);
        for (int k = 0; k < 100 && desc_valid_i; k++) tick(a);
        chk("desc_push_done", desc_valid_i, 0);
    endtask

    // Reference: R returns offset..end of line, then (wrap) the head beats, truncated to len+1
    task automatic model(input dsc_t d, input int n, input logic [DW-1:0] ld [8]);
        int lst[$];
        int cnt;
        if (d.fwd) begin
            for (int i = d.off; i < n && i < L; i++) lst.push_back(i);
            if (d.wrap && d.off > 0 && lst.size() <= d.len)
                for (int i = 0; i < d.off; i++) lst.push_back(i);
        end
        cnt = lst.size() < d.len + 1 ? lst.size() : d.len + 1;
        for (int k = 0; k < cnt; k++)
            exp_r.push_back({d.id, d.resp, 2'b00, k == cnt - 1, ld[lst[k]]});
        if (d.wb)
            for (int i = 0; i < n; i++)
                exp_w.push_back({d.user, {(DW / 8){1'b1}}, i == n - 1, ld[i]});
        exp_err += (n != L) ? 1 : 0;
    endtask

    task automatic send_line(input int n, input int stall_at);
        dsc_t d;
        logic [DW-1:0] ld [8];
        bit acc;
        d = dq.pop_front();
        for (int i = 0; i < 8; i++) ld[i] = {$urandom, $urandom};
        model(d, n, ld);
        for (int i = 0; i < n; i++) begin
            cd_valid_i = 1;
            cd_data_i  = ld[i];
            cd_last_i  = i == n - 1;
            if (i == stall_at) w_hold = 3;
            acc = 0;
            for (int k = 0; k < 200 && !acc; k++) tick(acc);
            chk("cd_accept", acc, 1);
        end
        cd_valid_i = 0;
        cd_last_i  = 0;
    endtask

    task automatic check_logs(input string tag);
        bit a;
        int m;
        for (int k = 0; k < 400 && busy_o; k++) tick(a);
        chk({tag, "_drained"}, busy_o, 0);
        chk({tag, "_r_count"}, r_n - r_rd, exp_r.size());
        m = (r_n - r_rd) < exp_r.size() ? r_n - r_rd : exp_r.size();
        for (int k = 0; k < m; k++) chk({tag, "_r_beat"}, r_log[r_rd + k], exp_r[k]);
        chk({tag, "_w_count"}, w_n - w_rd, exp_w.size());
        m = (w_n - w_rd) < exp_w.size() ? w_n - w_rd : exp_w.size();
        for (int k = 0; k < m; k++) chk({tag, "_w_beat"}, w_log[w_rd + k], exp_w[k]);
        chk({tag, "_err_pulses"}, err_n - err_rd, exp_err);
        r_rd = r_n;
        w_rd = w_n;
        err_rd = err_n;
        exp_err = 0;
        exp_r.delete();
        exp_w.delete();
    endtask

    function automatic dsc_t mk(int id, int len, int off, int resp, bit fwd, bit wb, bit wrap);
        dsc_t d;
        d.id = IW'(id);
        d.len = len;
        d.off = off;
        d.resp = 2'(resp);
        d.user = UW'(id);
        d.fwd = fwd;
        d.wb = wb;
        d.wrap = wrap;
        return d;
    endfunction

    initial begin
        bit a;
        int base, nd;
        dsc_t d;
        rst_i = 1;
        tick(a);
        tick(a);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_w_valid", w_valid_o, 0);
        chk("rst_cd_ready", cd_ready_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_desc_ready", desc_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        rst_i = 0;
        tick(a);

        push(mk(3, 1, 2, 0, 1, 0, 0));
        send_line(4, -1);
        check_logs("drop");

        push(mk(6, 3, 1, 1, 1, 0, 1));
        base = r_rd;
        send_line(4, -1);
        check_logs("wrap");
        for (int k = 0; k < 4; k++) chk("wrap_cd_ready", r_crdy[base + k], k < 3);

        push(mk(9, 3, 0, 2, 1, 1, 0));
        send_line(4, 1);
        check_logs("dual");

        for (int i = 1; i <= 4; i++) push(mk(i, 3, 0, i, 1, 1, 0));
        tick(a);
        chk("full_desc_ready", desc_ready_o, 0);
        put(mk(5, 3, 0, 1, 1, 1, 0));
        tick(a);
        chk("full_still_pending", desc_valid_i, 1);
        for (int i = 0; i < 5; i++) send_line(4, -1);
        chk("fifth_accepted", desc_valid_i, 0);
        check_logs("queue");

        push(mk(2, 3, 0, 0, 1, 1, 0));
        push(mk(4, 3, 1, 0, 1, 1, 0));
        send_line(3, -1);
        send_line(4, -1);
        check_logs("frame");

        push(mk(7, 3, 3, 3, 1, 0, 1));
        send_line(4, -1);
        r_pct = 0;
        tick(a);
        chk("replay_r_valid", r_valid_o, 1);
        chk("replay_cd_ready", cd_ready_o, 0);
        rst_i = 1;
        tick(a);
        rst_i = 0;
        chk("mid_rst_r_valid", r_valid_o, 0);
        chk("mid_rst_w_valid", w_valid_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_desc_ready", desc_ready_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        r_pct = 100;
        while (exp_r.size() > 1) void'(exp_r.pop_back());
        check_logs("reset");

        for (int g = 0; g < 10; g++) begin
            nd = int'($urandom_range(1, 4));
            r_pct = int'($urandom_range(40, 100));
            w_pct = int'($urandom_range(40, 100));
            for (int i = 0; i < nd; i++) begin
                d = mk(int'($urandom_range(15)), int'($urandom_range(5)), int'($urandom_range(3)),
                       int'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'($urandom));
                push(d);
            end
            for (int i = 0; i < nd; i++) send_line(4, -1);
            check_logs("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
